score_display: RTL and testbench
================================

Name: score_display

Overview:
- Downstream display stage for the game controller: converts the binary game score into four multiplexed, active-low seven-segment digits and drives the board's `seg` and `an` pins.
- Binary-to-BCD conversion is a sequential double-dabble engine with a load/busy handshake.
- The digit scanner runs continuously from a refresh divider, independent of conversion.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (1 kHz per digit at a 50 MHz clk); minimum 2.
- CNT_W, 16, width of the refresh counter; must satisfy 2^CNT_W >= REFRESH_DIV.
- BLANK_LZ, 1, 1 = blank leading zeros (digit 0 is never blanked); 0 = show all four digits.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- score  input  14  binary score, sampled only when a load is accepted.
- load  input  1  one-cycle request to convert and display `score`.
- busy  output  1  high while a conversion is in progress.
- seg  output  8  active-low segments; seg[6:0] = g..a, seg[7] = dp.
- an  output  4  active-low digit enables; an[0] is the rightmost digit (units).

Behaviour:
- Reset (reset=0, asynchronous):
  - seg=8'hFF, an=4'b1111, busy=0.
  - Display BCD register = 0000, digit index = 0, refresh counter = 0, FSM = IDLE.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: on load=1 at edge E0, capture min(score, 9999), clear the BCD accumulator, clear the shift count, go to SHIFT. busy=1 after E0.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. Exactly 14 iterations, at edges E1..E14, then go to DONE.
  - DONE (edge E15): copy the accumulator into the display register, busy=0 after E15, return to IDLE.
  - Total latency: the new digits are visible from the cycle after E15.
  - load while busy=1, including the DONE cycle, is ignored and not queued.
  - load is level-sampled only in IDLE: holding load high restarts a conversion on every return to IDLE, which is legal.
- Saturation: score > 9999 (14-bit maximum is 16383) converts as 9999.
- Scanner:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→2→3→0.
  - an = active-low one-hot of the index (index 0 → 4'b1110, index 3 → 4'b0111).
- seg encoding (registered, so seg/an update together one cycle after the index changes):
  - Decoder: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, dp bit 7 = 1, i.e. off).
  - A nibble > 9 cannot occur; if it does, decode it as 8'hFF.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i (i = 1..3) is blank when it and all higher digits are 0.
  - A blank digit gives seg=8'hFF; `an` still cycles normally.
- First cycle after reset release: an=4'b1110, seg=8'hC0.
- The display register changes only in DONE. The scanner never tears a digit: seg and an always come from the same index in the same cycle.
- Reset asserted mid-conversion: the conversion aborts, busy=0, and the display returns to 0. A subsequent load works normally.

Test Plan (REFRESH_DIV=4 on the bench):
- Reset release, no load → an=1110/seg=C0 first, then an 1101, 1011, 0111 all with seg=FF, each slot held 4 cycles.
- load with score=1234 → busy high for exactly 15 cycles (high after E0, low after E15). Scan then shows an1110:99, an1101:B0, an1011:A4, an0111:F9.
- score=42, BLANK_LZ=1 → an0:A4, an1:99, an2:FF, an3:FF. Same with BLANK_LZ=0 → an2:C0, an3:C0.
- score=12000 → all four digits 90 (9999). score=9999 → identical result.
- load=1 pulsed at E5 of a 1234 conversion with score=5678 → ignored. Display shows 1234, and busy falls after E15 as normal.
- reset pulsed low at E7 of a conversion → busy=0, an=1111, seg=FF immediately. After release the display shows 0; a new load of 7 → an0:F8.

Source files
------------

// File: rtl/score_display.sv
// score_display: binary score to four multiplexed active-low seven-segment digits
module score_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] score,
    input  logic        load,
    output logic        busy,
    output logic [7:0]  seg,
    output logic [3:0]  an
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [13:0]      bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [15:0]      disp_q, disp_d;
    logic [3:0]       it_q, it_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic [15:0]      adj;
    logic [3:0]       nib;
    logic             wrap;
    logic             blank;

    function automatic logic [7:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 8'hC0;
            4'd1:    decode = 8'hF9;
            4'd2:    decode = 8'hA4;
            4'd3:    decode = 8'hB0;
            4'd4:    decode = 8'h99;
            4'd5:    decode = 8'h92;
            4'd6:    decode = 8'h82;
            4'd7:    decode = 8'hF8;
            4'd8:    decode = 8'h80;
            4'd9:    decode = 8'h90;
            default: decode = 8'hFF;
        endcase
    endfunction

    // double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++)
            adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end

    // conversion FSM: capture saturated score, 14 shift steps, then publish to the display
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        it_d    = it_q;
        disp_d  = disp_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = (score > 14'd9999) ? 14'd9999 : score;
                    bcd_d   = '0;
                    it_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
                it_d           = it_q + 4'd1;
                state_d        = (it_q == 4'd13) ? DONE : SHIFT;
            end
            DONE: begin
                disp_d  = bcd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // scanner: refresh divider advances the digit index; seg/an are built from one index
    always_comb begin
        wrap  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        nib   = disp_q[{idx_q, 2'b00} +: 4];
        blank = BLANK_LZ && (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'd0);
        seg_d = blank ? 8'hFF : decode(nib);
        an_d  = ~(4'b0001 << idx_q);
    end

    // all state registers; reset aborts any conversion and blanks the outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            it_q    <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hFF;
            an_q    <= 4'b1111;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            it_q    <= it_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign seg  = seg_q;
    assign an   = an_q;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: scoreboard bench for score_display with and without leading-zero blanking
module tb_score_display;
    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        load  = 1'b0;
    logic [13:0] score = '0;
    logic        busy_lz, busy_all;
    logic [7:0]  seg_lz, seg_all;
    logic [3:0]  an_lz, an_all;
    int          checks = 0;
    int          passed = 0;
    bit          cap = 1'b0;

    typedef struct {
        logic [31:0] lz;
        logic [31:0] all;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    score_display #(.REFRESH_DIV(4), .CNT_W(3), .BLANK_LZ(1'b1)) u_lz (
        .clk(clk), .reset(reset), .score(score), .load(load),
        .busy(busy_lz), .seg(seg_lz), .an(an_lz)
    );

    score_display #(.REFRESH_DIV(4), .CNT_W(3), .BLANK_LZ(1'b0)) u_all (
        .clk(clk), .reset(reset), .score(score), .load(load),
        .busy(busy_all), .seg(seg_all), .an(an_all)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic issue(input logic [13:0] v, input logic [31:0] lz, input logic [31:0] all);
        exp_t e;
        e.lz  = lz;
        e.all = all;
        @(posedge clk);
        #1 score = v;
        load = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while ((q.size() != 0 || cap) && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            $display("FAIL %s: timeout waiting for conversion result", name);
        end
    endtask

    // monitor: measure busy length, and on each busy fall capture a full scan and compare
    initial begin
        int bcnt = 0;
        bit pb = 1'b0;
        logic [31:0] got_lz, got_all;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bcnt = 0;
                pb   = 1'b0;
            end else if (busy_lz) begin
                bcnt++;
                pb = 1'b1;
            end else if (pb) begin
                pb = 1'b0;
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: busy fell with no conversion pending");
                end else begin
                    cap = 1'b1;
                    e = q.pop_front();
                    chk("busy_len", bcnt, 32'd15);
                    got_lz  = '0;
                    got_all = '0;
                    for (int k = 0; k < 20; k++) begin
                        @(negedge clk);
                        for (int j = 0; j < 4; j++) begin
                            if (an_lz == ~(4'b0001 << j)) got_lz[j*8 +: 8] = seg_lz;
                            if (an_all == ~(4'b0001 << j)) got_all[j*8 +: 8] = seg_all;
                        end
                    end
                    chk("digits_lz", got_lz, e.lz);
                    chk("digits_all", got_all, e.all);
                    cap = 1'b0;
                end
                bcnt = 0;
            end
        end
    end

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("rst_seg", seg_lz, 8'hFF);
        chk("rst_an", an_lz, 4'b1111);
        chk("rst_busy", busy_lz, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("first_an", an_lz, 4'b1110);
        chk("first_seg", seg_lz, 8'hC0);
        repeat (3) @(posedge clk);
        #1 chk("slot0_hold", an_lz, 4'b1110);
        @(posedge clk);
        #1;
        chk("slot1_an", an_lz, 4'b1101);
        chk("slot1_seg_lz", seg_lz, 8'hFF);
        chk("slot1_seg_all", seg_all, 8'hC0);
        repeat (4) @(posedge clk);
        #1;
        chk("slot2_an", an_lz, 4'b1011);
        chk("slot2_seg_lz", seg_lz, 8'hFF);
        repeat (4) @(posedge clk);
        #1;
        chk("slot3_an", an_lz, 4'b0111);
        chk("slot3_seg_lz", seg_lz, 8'hFF);
        issue(14'd1234, 32'hF9A4B099, 32'hF9A4B099);
        wait_done("s1234");
        issue(14'd42, 32'hFFFF99A4, 32'hC0C099A4);
        wait_done("s42");
        issue(14'd0, 32'hFFFFFFC0, 32'hC0C0C0C0);
        wait_done("s0");
        issue(14'd1000, 32'hF9C0C0C0, 32'hF9C0C0C0);
        wait_done("s1000");
        issue(14'd12000, 32'h90909090, 32'h90909090);
        wait_done("s12000");
        issue(14'd9999, 32'h90909090, 32'h90909090);
        wait_done("s9999");
        issue(14'd16383, 32'h90909090, 32'h90909090);
        wait_done("s16383");
        issue(14'd1234, 32'hF9A4B099, 32'hF9A4B099);
        repeat (4) @(posedge clk);
        #1 score = 14'd5678;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_done("ignored_load");
        @(posedge clk);
        #1 score = 14'd5678;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", busy_lz, 1'b0);
        chk("abort_an", an_lz, 4'b1111);
        chk("abort_seg", seg_lz, 8'hFF);
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_abort_an", an_lz, 4'b1110);
        chk("post_abort_seg", seg_lz, 8'hC0);
        issue(14'd7, 32'hFFFFFFF8, 32'hC0C0C0F8);
        wait_done("s7");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
